// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants and control-state encoding shared by the alu_seq slice.
package alu_pkg;

    localparam logic [2:0] OP_NEG   = 3'd0;
    localparam logic [2:0] OP_INC   = 3'd1;
    localparam logic [2:0] OP_ADC   = 3'd2;
    localparam logic [2:0] OP_ADDSR = 3'd3;
    localparam logic [2:0] OP_AND   = 3'd4;
    localparam logic [2:0] OP_OR    = 3'd5;
    localparam logic [2:0] OP_PACK  = 3'd6;
    localparam logic [2:0] OP_MUL   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/opcode request channel and result/flag response channel of alu_seq.
interface alu_seq_if #(parameter int WIDTH = 16);

    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] inA;
    logic [WIDTH-1:0] inB;
    logic             inC;
    logic [2:0]       opc;
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] outW;
    logic             zer;
    logic             neg;
    logic             cout;
    logic             ovf;

    modport master (
        output inValid, inA, inB, inC, opc, outReady,
        input  inReady, outValid, outW, zer, neg, cout, ovf
    );

    modport slave (
        input  inValid, inA, inB, inC, opc, outReady,
        output inReady, outValid, outW, zer, neg, cout, ovf
    );

endinterface

// File: rtl/alu_seq_comb.sv
// alu_seq_comb: combinational core for opcodes 0-6; opcode 7 yields zero result and flags.
module alu_seq_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_c,
    input  logic [2:0]       i_opc,
    output logic [WIDTH-1:0] o_res,
    output logic             o_cout,
    output logic             o_ovf
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] w_addb;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;
    logic             w_add_ovf;

    // Second adder operand and carry-in for the three add-type opcodes
    always_comb begin
        w_addb = i_b;
        w_cin  = i_c;
        case (i_opc)
            OP_INC: begin
                w_addb = {WIDTH{1'b0}};
                w_cin  = 1'b1;
            end
            OP_ADDSR: begin
                w_addb = {i_b[WIDTH-1], i_b[WIDTH-1:1]};
                w_cin  = 1'b0;
            end
            default: begin
                w_addb = i_b;
                w_cin  = i_c;
            end
        endcase
    end

    assign w_sum     = {1'b0, i_a} + {1'b0, w_addb} + {{WIDTH{1'b0}}, w_cin};
    assign w_add_ovf = (i_a[WIDTH-1] == w_addb[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);

    // Result and carry/overflow select
    always_comb begin
        o_res  = {WIDTH{1'b0}};
        o_cout = 1'b0;
        o_ovf  = 1'b0;
        case (i_opc)
            OP_NEG: begin
                o_res  = ~i_a + ONE;
                o_cout = (i_a == {WIDTH{1'b0}});
                o_ovf  = (i_a == MIN);
            end
            OP_INC, OP_ADC, OP_ADDSR: begin
                o_res  = w_sum[WIDTH-1:0];
                o_cout = w_sum[WIDTH];
                o_ovf  = w_add_ovf;
            end
            OP_AND:  o_res = i_a & i_b;
            OP_OR:   o_res = i_a | i_b;
            OP_PACK: o_res = {i_a[WIDTH/2-1:0], i_b[WIDTH/2-1:0]};
            default: begin
                o_res  = {WIDTH{1'b0}};
                o_cout = 1'b0;
                o_ovf  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result/flags held until writeback takes them.
// Macro ALU_SEQ_MUL_EN builds the WIDTH-cycle shift-add multiply on opcode 7.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic     clk,
    input  logic     rstN,
    alu_seq_if.slave bus
);

    state_t           r_state;
    logic             r_live;
    logic [WIDTH-1:0] r_w;
    logic             r_zer;
    logic             r_neg;
    logic             r_cout;
    logic             r_ovf;

    logic [WIDTH-1:0] w_res;
    logic             w_cout;
    logic             w_ovf;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_start_mul;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_res;
    logic             w_mul_ovf;

    alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
        .i_a    (bus.inA),
        .i_b    (bus.inB),
        .i_c    (bus.inC),
        .i_opc  (bus.opc),
        .o_res  (w_res),
        .o_cout (w_cout),
        .o_ovf  (w_ovf)
    );

    // r_live keeps the block closed until the first clock after reset release
    assign w_in_ready = r_live && ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && bus.outReady));
    assign w_accept   = bus.inValid && w_in_ready;

`ifdef ALU_SEQ_MUL_EN
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] r_mul_a;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0]   r_mul_b;
    logic [CW-1:0]      r_cnt;

    assign w_start_mul = w_accept && (bus.opc == OP_MUL);
    assign w_acc_next  = r_acc + (r_mul_b[0] ? r_mul_a : {(2*WIDTH){1'b0}});
    assign w_mul_done  = (r_state == ST_MUL) && (r_cnt == CW'(1));
    assign w_mul_res   = w_acc_next[WIDTH-1:0];
    assign w_mul_ovf   = |w_acc_next[2*WIDTH-1:WIDTH];

    // Shift-add datapath: one multiplier bit per cycle, LSB first
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_mul_a <= {(2*WIDTH){1'b0}};
            r_mul_b <= {WIDTH{1'b0}};
            r_acc   <= {(2*WIDTH){1'b0}};
            r_cnt   <= {CW{1'b0}};
        end else if (w_start_mul) begin
            r_mul_a <= {{WIDTH{1'b0}}, bus.inA};
            r_mul_b <= bus.inB;
            r_acc   <= {(2*WIDTH){1'b0}};
            r_cnt   <= CW'(WIDTH);
        end else if (r_state == ST_MUL) begin
            r_mul_a <= r_mul_a << 1;
            r_mul_b <= r_mul_b >> 1;
            r_acc   <= w_acc_next;
            r_cnt   <= r_cnt - CW'(1);
        end else begin
            r_mul_a <= r_mul_a;
            r_mul_b <= r_mul_b;
            r_acc   <= r_acc;
            r_cnt   <= r_cnt;
        end
    end
`else
    assign w_start_mul = 1'b0;
    assign w_mul_done  = 1'b0;
    assign w_mul_res   = {WIDTH{1'b0}};
    assign w_mul_ovf   = 1'b0;
`endif

    // Control FSM with registered result and flags
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= ST_IDLE;
            r_live  <= 1'b0;
            r_w     <= {WIDTH{1'b0}};
            r_zer   <= 1'b0;
            r_neg   <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                ST_IDLE, ST_HOLD: begin
                    if (w_start_mul) begin
                        r_state <= ST_MUL;
                    end else if (w_accept) begin
                        r_state <= ST_HOLD;
                        r_w     <= w_res;
                        r_zer   <= (w_res == {WIDTH{1'b0}});
                        r_neg   <= w_res[WIDTH-1];
                        r_cout  <= w_cout;
                        r_ovf   <= w_ovf;
                    end else if (bus.outReady) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= r_state;
                    end
                end
                ST_MUL: begin
                    if (w_mul_done) begin
                        r_state <= ST_HOLD;
                        r_w     <= w_mul_res;
                        r_zer   <= (w_mul_res == {WIDTH{1'b0}});
                        r_neg   <= w_mul_res[WIDTH-1];
                        r_cout  <= 1'b0;
                        r_ovf   <= w_mul_ovf;
                    end else begin
                        r_state <= ST_MUL;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.inReady  = w_in_ready;
    assign bus.outValid = (r_state == ST_HOLD);
    assign bus.outW     = r_w;
    assign bus.zer      = r_zer;
    assign bus.neg      = r_neg;
    assign bus.cout     = r_cout;
    assign bus.ovf      = r_ovf;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq at WIDTH=16; expected results come from an
// integer-arithmetic reference model. Honours ALU_SEQ_MUL_EN the same way as the design.
module tb_alu_seq;

    typedef struct packed {
        logic [15:0] w;
        logic        zer;
        logic        neg;
        logic        cout;
        logic        ovf;
    } res_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic [15:0] w;
    } vec_t;

    logic clk;
    logic rstN;
    int   n_pass  = 0;
    int   n_total = 0;
    res_t sb[$];
    res_t exp_r;
    res_t got;

    alu_seq_if #(.WIDTH(16)) bus ();

    alu_seq #(.WIDTH(16)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [2:0] op, input logic [15:0] a,
                                   input logic [15:0] b, input logic c);
        res_t        r;
        int          sa;
        int          sbi;
        int          s;
        logic [16:0] full;
        logic [31:0] p;
        logic        is_add;
        r      = '0;
        sa     = int'($signed(a));
        sbi    = int'($signed(b));
        s      = 0;
        full   = 17'd0;
        p      = 32'd0;
        is_add = 1'b0;
        case (op)
            3'd0: begin
                r.w    = 16'(0 - int'(a));
                r.cout = (a == 16'd0);
                r.ovf  = (a == 16'h8000);
            end
            3'd1: begin full = {1'b0, a} + 17'd1; s = sa + 1; is_add = 1'b1; end
            3'd2: begin
                full = {1'b0, a} + {1'b0, b} + {16'd0, c};
                s = sa + sbi + int'(c);
                is_add = 1'b1;
            end
            3'd3: begin
                full = {1'b0, a} + {1'b0, 16'(sbi >>> 1)};
                s = sa + (sbi >>> 1);
                is_add = 1'b1;
            end
            3'd4: r.w = a & b;
            3'd5: r.w = a | b;
            3'd6: r.w = {a[7:0], b[7:0]};
            default: begin
`ifdef ALU_SEQ_MUL_EN
                p     = {16'd0, a} * {16'd0, b};
                r.w   = p[15:0];
                r.ovf = (p[31:16] != 16'd0);
`else
                r.w = 16'd0;
`endif
            end
        endcase
        if (is_add) begin
            r.w    = full[15:0];
            r.cout = full[16];
            r.ovf  = (s > 32767) || (s < -32768);
        end
        r.zer = (r.w == 16'd0);
        r.neg = r.w[15];
        return r;
    endfunction

    task automatic drive_op(input logic [2:0] op, input logic [15:0] a,
                            input logic [15:0] b, input logic c);
        bus.opc     = op;
        bus.inA     = a;
        bus.inB     = b;
        bus.inC     = c;
        bus.inValid = 1'b1;
        sb.push_back(model(op, a, b, c));
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({bus.outValid, bus.outW, bus.zer, bus.neg, bus.cout, bus.ovf} !== 21'd0)
            $display("FAIL reset_outputs: got %h want 000000",
                     {bus.outValid, bus.outW, bus.zer, bus.neg, bus.cout, bus.ovf});
        else n_pass++;
        rstN = 1'b1;
        @(negedge clk);
        n_total++;
        if (bus.inReady !== 1'b1) $display("FAIL reset_inready: got %b want 1", bus.inReady);
        else n_pass++;
    endtask

    task automatic test_single_ops();
        vec_t tbl[13] = '{
            '{3'd2, 16'hFFFF, 16'h0000, 1'b1, 16'h0000},
            '{3'd3, 16'h0001, 16'h8000, 1'b0, 16'hC001},
            '{3'd6, 16'h12AB, 16'h34CD, 1'b0, 16'hABCD},
            '{3'd0, 16'h0000, 16'h0000, 1'b0, 16'h0000},
            '{3'd0, 16'h8000, 16'h0000, 1'b0, 16'h8000},
            '{3'd0, 16'h0005, 16'h1234, 1'b1, 16'hFFFB},
            '{3'd1, 16'h7FFF, 16'h0000, 1'b1, 16'h8000},
            '{3'd1, 16'hFFFF, 16'h0000, 1'b0, 16'h0000},
            '{3'd2, 16'h7000, 16'h1000, 1'b0, 16'h8000},
            '{3'd4, 16'hF0F0, 16'h3C3C, 1'b1, 16'h3030},
            '{3'd5, 16'hF0F0, 16'h0F0F, 1'b0, 16'hFFFF},
            '{3'd3, 16'h0010, 16'h0003, 1'b1, 16'h0011},
            '{3'd2, 16'h8000, 16'h8000, 1'b0, 16'h0000}
        };
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            n_total++;
            if (bus.inReady !== 1'b1) $display("FAIL ops_ready[%0d]: got %b want 1", i, bus.inReady);
            else n_pass++;
            drive_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].c);
            bus.outReady = 1'b0;
            @(negedge clk);
            bus.inValid = 1'b0;
            n_total++;
            if (bus.outValid !== 1'b1) $display("FAIL ops_valid[%0d]: got %b want 1", i, bus.outValid);
            else n_pass++;
            exp_r = sb.pop_front();
            got   = {bus.outW, bus.zer, bus.neg, bus.cout, bus.ovf};
            n_total++;
            if (got !== exp_r) $display("FAIL ops_result[%0d] op%0d: got %h want %h", i, tbl[i].op, got, exp_r);
            else n_pass++;
            n_total++;
            if (bus.outW !== tbl[i].w) $display("FAIL ops_const[%0d]: got %h want %h", i, bus.outW, tbl[i].w);
            else n_pass++;
            bus.outReady = 1'b1;
            @(negedge clk);
            bus.outReady = 1'b0;
        end
    endtask

`ifdef ALU_SEQ_MUL_EN
    task automatic test_mul();
        logic [15:0] ma[3] = '{16'h0003, 16'h0100, 16'hFFFF};
        logic [15:0] mb[3] = '{16'h0005, 16'h0100, 16'hFFFF};
        logic [15:0] mw[3] = '{16'h000F, 16'h0000, 16'h0001};
        int lat;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_op(3'd7, ma[i], mb[i], 1'b0);
            bus.outReady = 1'b0;
            @(negedge clk);
            bus.inValid = 1'b0;
            n_total++;
            if (bus.inReady !== 1'b0 || bus.outValid !== 1'b0)
                $display("FAIL mul_busy[%0d]: got ready=%b valid=%b want 0 0", i, bus.inReady, bus.outValid);
            else n_pass++;
            lat = 0;
            while (bus.outValid !== 1'b1 && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            n_total++;
            if (lat !== 16) $display("FAIL mul_latency[%0d]: got %0d want 16", i, lat);
            else n_pass++;
            exp_r = sb.pop_front();
            got   = {bus.outW, bus.zer, bus.neg, bus.cout, bus.ovf};
            n_total++;
            if (got !== exp_r) $display("FAIL mul_result[%0d]: got %h want %h", i, got, exp_r);
            else n_pass++;
            n_total++;
            if (bus.outW !== mw[i]) $display("FAIL mul_const[%0d]: got %h want %h", i, bus.outW, mw[i]);
            else n_pass++;
            bus.outReady = 1'b1;
            @(negedge clk);
            bus.outReady = 1'b0;
        end
    endtask
`else
    task automatic test_mul_disabled();
        @(negedge clk);
        drive_op(3'd7, 16'h0003, 16'h0005, 1'b0);
        bus.outReady = 1'b0;
        @(negedge clk);
        bus.inValid = 1'b0;
        n_total++;
        if (bus.outValid !== 1'b1) $display("FAIL nomul_valid: got %b want 1", bus.outValid);
        else n_pass++;
        exp_r = sb.pop_front();
        got   = {bus.outW, bus.zer, bus.neg, bus.cout, bus.ovf};
        n_total++;
        if (got !== exp_r) $display("FAIL nomul_result: got %h want %h", got, exp_r);
        else n_pass++;
        n_total++;
        if ({bus.outW, bus.zer} !== 17'h00001) $display("FAIL nomul_const: got %h want 00001", {bus.outW, bus.zer});
        else n_pass++;
        bus.outReady = 1'b1;
        @(negedge clk);
        bus.outReady = 1'b0;
    endtask
`endif

    task automatic test_backpressure();
        @(negedge clk);
        drive_op(3'd2, 16'h1234, 16'h1111, 1'b0);
        bus.outReady = 1'b0;
        @(negedge clk);
        bus.opc = 3'd5;
        bus.inA = 16'hFFFF;
        bus.inB = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (bus.inReady !== 1'b0) $display("FAIL bp_ready[%0d]: got %b want 0", i, bus.inReady);
            else n_pass++;
            got = {bus.outW, bus.zer, bus.neg, bus.cout, bus.ovf};
            n_total++;
            if (got !== sb[0]) $display("FAIL bp_hold[%0d]: got %h want %h", i, got, sb[0]);
            else n_pass++;
            @(negedge clk);
        end
        bus.inValid = 1'b0;
        exp_r = sb.pop_front();
        got   = {bus.outW, bus.zer, bus.neg, bus.cout, bus.ovf};
        n_total++;
        if (got !== exp_r || bus.outValid !== 1'b1)
            $display("FAIL bp_result: got %h valid=%b want %h valid=1", got, bus.outValid, exp_r);
        else n_pass++;
        bus.outReady = 1'b1;
        @(negedge clk);
        bus.outReady = 1'b0;
        n_total++;
        if (bus.outValid !== 1'b0) $display("FAIL bp_drain: got %b want 0", bus.outValid);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bus.outReady = 1'b1;
        @(negedge clk);
        drive_op(3'd1, 16'h7FFD, 16'h0000, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            n_total++;
            if (bus.outValid !== 1'b1 || bus.inReady !== 1'b1)
                $display("FAIL b2b_flow[%0d]: got valid=%b ready=%b want 1 1", i, bus.outValid, bus.inReady);
            else n_pass++;
            exp_r = sb.pop_front();
            got   = {bus.outW, bus.zer, bus.neg, bus.cout, bus.ovf};
            n_total++;
            if (got !== exp_r) $display("FAIL b2b_result[%0d]: got %h want %h", i, got, exp_r);
            else n_pass++;
            if (i < 4) drive_op(3'd1, 16'h7FFD + 16'(i), 16'h0000, 1'b0);
            else bus.inValid = 1'b0;
        end
        @(negedge clk);
        n_total++;
        if (bus.outValid !== 1'b0) $display("FAIL b2b_drain: got %b want 0", bus.outValid);
        else n_pass++;
        bus.outReady = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic seen;
        @(negedge clk);
`ifdef ALU_SEQ_MUL_EN
        drive_op(3'd7, 16'h00FF, 16'h00FF, 1'b0);
        bus.outReady = 1'b0;
        @(negedge clk);
        bus.inValid = 1'b0;
        repeat (7) @(negedge clk);
`else
        drive_op(3'd5, 16'h00F0, 16'h0F00, 1'b0);
        bus.outReady = 1'b0;
        @(negedge clk);
        bus.inValid = 1'b0;
`endif
        rstN = 1'b0;
        #1;
        n_total++;
        if ({bus.outValid, bus.outW} !== 17'd0) $display("FAIL rst_mid_clear: got %h want 00000", {bus.outValid, bus.outW});
        else n_pass++;
        sb.delete();
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        n_total++;
        if (bus.inReady !== 1'b1) $display("FAIL rst_mid_ready: got %b want 1", bus.inReady);
        else n_pass++;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.outValid === 1'b1) seen = 1'b1;
        end
        n_total++;
        if (seen !== 1'b0) $display("FAIL rst_mid_noresult: got %b want 0", seen);
        else n_pass++;
        drive_op(3'd4, 16'hA5A5, 16'h0FF0, 1'b0);
        @(negedge clk);
        bus.inValid = 1'b0;
        exp_r = sb.pop_front();
        got   = {bus.outW, bus.zer, bus.neg, bus.cout, bus.ovf};
        n_total++;
        if (got !== exp_r || bus.outValid !== 1'b1)
            $display("FAIL rst_mid_and: got %h valid=%b want %h valid=1", got, bus.outValid, exp_r);
        else n_pass++;
        bus.outReady = 1'b1;
        @(negedge clk);
        bus.outReady = 1'b0;
    endtask

    initial begin
        clk          = 1'b0;
        rstN         = 1'b0;
        bus.inValid  = 1'b0;
        bus.inA      = 16'h0000;
        bus.inB      = 16'h0000;
        bus.inC      = 1'b0;
        bus.opc      = 3'd0;
        bus.outReady = 1'b0;
        test_reset();
        test_single_ops();
`ifdef ALU_SEQ_MUL_EN
        test_mul();
`else
        test_mul_disabled();
`endif
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no completion want completion");
        $fatal(1);
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the CA3 combinational ALU. Keeps the seven-opcode set, generalised to `WIDTH` bits. Adds registered results, carry-out and overflow flags, valid/ready flow control and an optional multi-cycle shift-add multiply on opcode 7. It sits between the datapath register file and the writeback stage; its result is held until writeback accepts it.

## Interface
- `WIDTH`, 16: operand/result width; must be even and ≥ 4.
- `clk`  in  1  rising-edge clock.
- `rstN`  in  1  reset; asynchronous, active-low.
- `inValid`  in  1  operands and opcode valid.
- `inReady`  out  1  block accepts an operation this cycle.
- `inA`, `inB`  in  WIDTH  operands.
- `inC`  in  1  carry-in; used by opcode 2 only.
- `opc`  in  3  operation select.
- `outValid`  out  1  result registers hold an unconsumed result.
- `outReady`  in  1  consumer takes the result this cycle.
- `outW`  out  WIDTH  result.
- `zer`, `neg`, `cout`, `ovf`  out  1  result flags.

## Operation
- Accept occurs when `inValid && inReady`. Operands, `opc` and `inC` are sampled at that edge only.
- Opcodes:
  - 0: `~A+1`. `cout` = (A==0).
  - 1: `A+1`.
  - 2: `A+B+inC`.
  - 3: `A + {B[W-1], B[W-1:1]}` (arithmetic shift right of B by 1).
  - 4: `A&B`.
  - 5: `A|B`.
  - 6: `{A[W/2-1:0], B[W/2-1:0]}`.
  - 7: `A*B`, unsigned, low WIDTH bits.
- Width: all adds are computed at WIDTH+1 bits. `cout` = bit WIDTH (opcodes 1–3). `ovf` = signed overflow (opcodes 1–3; opcode 0 when A = 100…0). For opcode 7, `ovf` = high half of the product nonzero and `cout` = 0. All other flag cases are 0.
- `zer` = (`outW`==0) and `neg` = `outW[W-1]`, evaluated on the registered result.
- FSM:
  - IDLE: `inReady`=1. A single-cycle op goes to HOLD. Opcode 7 goes to MUL.
  - MUL: `inReady`=0. 1 bit per cycle, LSB first: B shifted right, A shifted left, conditional accumulate into a 2×WIDTH accumulator. Cycle counter loaded with WIDTH at accept. Goes to HOLD when the counter reaches 0.
  - HOLD: `outValid`=1. `inReady` = `outReady`.
    - `outReady` with no accept: go to IDLE.
    - `outReady` with a single-cycle accept: result replaced, stay in HOLD.
    - `outReady` with an opcode-7 accept: go to MUL.
- `outW` and flags are stable while `outValid && !outReady`. Inputs are ignored when not ready.
- Reset: async clear to IDLE. `outValid`=0, `outW`=0, all flags 0, accumulator/counter 0. `inReady`=1 from the first clock after deassertion. Reset mid-MUL abandons the operation with no result.

## Timing
- Single-cycle ops: accepted at edge k, result and `outValid` visible after edge k. Latency 1, throughput 1/cycle with `outReady` held high.
- Multiply: accepted at edge k, `outValid` asserts after edge k+WIDTH (16 cycles at default). Throughput 1 per WIDTH+1 cycles.
- No combinational path from `inA`/`inB`/`opc` to any output. `inReady` depends combinationally on `outReady` only in HOLD.

## Configuration
- `ALU_SEQ_MUL_EN` defined: opcode 7 is the multi-cycle multiply; the MUL state, counter and accumulator exist.
- `ALU_SEQ_MUL_EN` undefined: no MUL state. Opcode 7 completes as a single-cycle op with `outW`=0, `zer`=1 and all other flags 0.

## Structure
- Shared package `alu_pkg` holds:
  - opcode constants `OP_NEG`, `OP_INC`, `OP_ADC`, `OP_ADDSR`, `OP_AND`, `OP_OR`, `OP_PACK`, `OP_MUL`;
  - the FSM state encoding (IDLE/MUL/HOLD).
- One sub-module, `alu_seq_comb`: the WIDTH-parametrised combinational core for opcodes 0–6, producing result, `cout` and `ovf`. The top holds the FSM, registers and multiplier.

## Test plan
- Opcode 2, A=0xFFFF, B=0x0000, inC=1 → next cycle `outW`=0x0000, `zer`=1, `cout`=1, `ovf`=0.
- Opcode 3, A=0x0001, B=0x8000 → `outW`=0xC001, `neg`=1. Opcode 6, A=0x12AB, B=0x34CD → `outW`=0xABCD.
- Opcode 7, A=3, B=5 → `outW`=0x000F with `outValid` exactly 16 cycles after accept. A=0x0100, B=0x0100 → `outW`=0, `zer`=1, `ovf`=1.
- Backpressure: `outReady`=0 for 5 cycles after a result → `inReady`=0 and `outW`/flags unchanged. Then stream 4 opcode-1 ops with `outReady`=1 → 4 results on 4 consecutive cycles.
- `rstN` pulled low at MUL cycle 8 → `outValid`=0 immediately. After release, `inReady`=1 and a new opcode-4 op completes normally.
- Without `ALU_SEQ_MUL_EN`: opcode 7 → 1-cycle latency, `outW`=0, `zer`=1.
